hazard_scoreboard_unit: RTL and testbench

//  Next-generation pipeline hazard unit for the 16-bit core. Per-operand forwarding select (EX/MEM over MEM/WB, r0 never

---
 rtl/hazard_scoreboard_unit.sv | 129 ++++++++++++
 tb/tb_hazard_scoreboard_unit.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard_unit.sv
// Pipeline hazard unit: per-operand EX forwarding select, load-use stall, and a
// per-register countdown scoreboard that tracks multi-cycle (MUL/DIV) results.
module hazard_scoreboard_unit #(
    parameter int REG_AW  = 4,
    parameter int NUM_SRC = 2,
    parameter int LAT_W   = 3,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      id_valid,
    input  logic [NUM_SRC*REG_AW-1:0] id_rs,
    input  logic [NUM_SRC-1:0]        id_rs_used,
    input  logic [REG_AW-1:0]         id_rd,
    input  logic                      id_reg_write,
    input  logic [LAT_W-1:0]          id_mc_lat,
    input  logic [NUM_SRC*REG_AW-1:0] idex_rs,
    input  logic [REG_AW-1:0]         idex_rd,
    input  logic                      idex_reg_write,
    input  logic                      idex_is_load,
    input  logic                      exmem_reg_write,
    input  logic [REG_AW-1:0]         exmem_rd,
    input  logic                      memwb_reg_write,
    input  logic [REG_AW-1:0]         memwb_rd,
    input  logic                      flush,
    input  logic                      clr_stats,
    output logic [2*NUM_SRC-1:0]      fwd_sel,
    output logic                      stall,
    output logic                      mc_busy,
    output logic [2**REG_AW-1:0]      busy_map,
    output logic [CNT_W-1:0]          stall_cycles
);

    localparam int NUM_REGS = 2**REG_AW;

    logic [LAT_W-1:0]   mc_cnt_reg;
    logic [CNT_W-1:0]   stall_cycles_reg;
    logic [NUM_SRC-1:0] lu_hit;
    logic [NUM_SRC-1:0] raw_hit;
    logic               load_use;
    logic               raw_sb;
    logic               waw_sb;
    logic               struct_sb;
    logic               issue;
    logic               mc_start;

    genvar gi;

    // Per-source forwarding select and hazard match terms
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            logic [REG_AW-1:0] ex_rs;
            logic [REG_AW-1:0] id_src;
            logic              counted;

            assign ex_rs  = idex_rs[gi*REG_AW +: REG_AW];
            assign id_src = id_rs[gi*REG_AW +: REG_AW];

            assign fwd_sel[2*gi +: 2] =
                (exmem_reg_write && (exmem_rd != '0) && (exmem_rd == ex_rs)) ? 2'b10 :
                (memwb_reg_write && (memwb_rd != '0) && (memwb_rd == ex_rs)) ? 2'b01 :
                                                                               2'b00;

            assign counted      = id_rs_used[gi] && (id_src != '0);
            assign lu_hit[gi]   = counted && (id_src == idex_rd);
            assign raw_hit[gi]  = counted && busy_map[id_src];
        end
    endgenerate

    assign load_use  = idex_is_load && idex_reg_write && (idex_rd != '0) && (|lu_hit);
    assign raw_sb    = |raw_hit;
    assign waw_sb    = id_reg_write && (id_rd != '0) && busy_map[id_rd];
    assign struct_sb = (id_mc_lat != '0) && mc_busy;

    // A redirect kills the ID instruction, so it never needs to be held
    assign stall    = id_valid && (load_use || raw_sb || waw_sb || struct_sb) && !flush;
    assign issue    = id_valid && !stall && !flush;
    assign mc_start = issue && (id_mc_lat != '0);

    // Register 0 is hardwired zero and never pending
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
            if (gi == 0) begin : g_zero
                assign busy_map[gi] = 1'b0;
            end else begin : g_cnt
                logic [LAT_W-1:0] cnt_reg;
                logic             load;

                assign load = mc_start && id_reg_write && (id_rd == REG_AW'(gi));

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        cnt_reg <= '0;
                    end else if (load) begin
                        cnt_reg <= id_mc_lat;
                    end else if (cnt_reg != '0) begin
                        cnt_reg <= cnt_reg - 1'b1;
                    end
                end

                assign busy_map[gi] = (cnt_reg != '0);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mc_cnt_reg <= '0;
        end else if (mc_start) begin
            mc_cnt_reg <= id_mc_lat;
        end else if (mc_cnt_reg != '0) begin
            mc_cnt_reg <= mc_cnt_reg - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_reg <= '0;
        end else if (clr_stats) begin
            stall_cycles_reg <= '0;
        end else if (stall && !(&stall_cycles_reg)) begin
            stall_cycles_reg <= stall_cycles_reg + 1'b1;
        end
    end

    assign mc_busy      = (mc_cnt_reg != '0);
    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Self-checking bench for hazard_scoreboard_unit: expected values are queued when
// stimulus is driven and popped/compared once the DUT output is sampled.
module tb_hazard_scoreboard_unit;

    logic        clk;
    logic        rst_n;
    logic        id_valid;
    logic [7:0]  id_rs;
    logic [1:0]  id_rs_used;
    logic [3:0]  id_rd;
    logic        id_reg_write;
    logic [2:0]  id_mc_lat;
    logic [7:0]  idex_rs;
    logic [3:0]  idex_rd;
    logic        idex_reg_write;
    logic        idex_is_load;
    logic        exmem_reg_write;
    logic [3:0]  exmem_rd;
    logic        memwb_reg_write;
    logic [3:0]  memwb_rd;
    logic        flush;
    logic        clr_stats;
    logic [3:0]  fwd_sel;
    logic        stall;
    logic        mc_busy;
    logic [15:0] busy_map;
    logic [3:0]  stall_cycles;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_checks = 0;
    int   n_fail   = 0;

    hazard_scoreboard_unit #(
        .REG_AW (4),
        .NUM_SRC(2),
        .LAT_W  (3),
        .CNT_W  (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid       (id_valid),
        .id_rs          (id_rs),
        .id_rs_used     (id_rs_used),
        .id_rd          (id_rd),
        .id_reg_write   (id_reg_write),
        .id_mc_lat      (id_mc_lat),
        .idex_rs        (idex_rs),
        .idex_rd        (idex_rd),
        .idex_reg_write (idex_reg_write),
        .idex_is_load   (idex_is_load),
        .exmem_reg_write(exmem_reg_write),
        .exmem_rd       (exmem_rd),
        .memwb_reg_write(memwb_reg_write),
        .memwb_rd       (memwb_rd),
        .flush          (flush),
        .clr_stats      (clr_stats),
        .fwd_sel        (fwd_sel),
        .stall          (stall),
        .mc_busy        (mc_busy),
        .busy_map       (busy_map),
        .stall_cycles   (stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        exp_q.push_back('{tag, val});
    endtask

    task automatic drive_idle();
        id_valid        = 1'b0;
        id_rs           = '0;
        id_rs_used      = '0;
        id_rd           = '0;
        id_reg_write    = 1'b0;
        id_mc_lat       = '0;
        idex_rs         = '0;
        idex_rd         = '0;
        idex_reg_write  = 1'b0;
        idex_is_load    = 1'b0;
        exmem_reg_write = 1'b0;
        exmem_rd        = '0;
        memwb_reg_write = 1'b0;
        memwb_rd        = '0;
        flush           = 1'b0;
        clr_stats       = 1'b0;
    endtask

    task automatic set_id(input logic [3:0] rs1, input logic [3:0] rs0, input logic [1:0] used,
                          input logic [3:0] rd, input logic wr, input logic [2:0] lat);
        id_valid     = 1'b1;
        id_rs        = {rs1, rs0};
        id_rs_used   = used;
        id_rd        = rd;
        id_reg_write = wr;
        id_mc_lat    = lat;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        push("reset_busy_map", 32'h0);
        push("reset_mc_busy", 32'h0);
        push("reset_stall_cycles", 32'h0);
        push("reset_stall", 32'h0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(busy_map) !== e.val) begin n_fail++; $display("FAIL %s got %0h expected %0h", e.tag, busy_map, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(mc_busy) !== e.val) begin n_fail++; $display("FAIL %s got %0h expected %0h", e.tag, mc_busy, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(stall_cycles) !== e.val) begin n_fail++; $display("FAIL %s got %0h expected %0h", e.tag, stall_cycles, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(stall) !== e.val) begin n_fail++; $display("FAIL %s got %0h expected %0h", e.tag, stall, e.val); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("reset: released");
    endtask

    task automatic test_forwarding();
        // {exmem_wr, exmem_rd, memwb_wr, memwb_rd, expected fwd_sel}; src0=r3, src1=r6
        logic [3:0] xr [5] = '{4'd3, 4'd0, 4'd0, 4'd3, 4'd3};
        logic       xw [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [3:0] mr [5] = '{4'd3, 4'd3, 4'd0, 4'd6, 4'd3};
        logic       mw [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        logic [3:0] ex [5] = '{4'b0010, 4'b0001, 4'b0000, 4'b0110, 4'b0001};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_idle();
            idex_rs         = {4'd6, 4'd3};
            exmem_reg_write = xw[i];
            exmem_rd        = xr[i];
            memwb_reg_write = mw[i];
            memwb_rd        = mr[i];
            push($sformatf("fwd_case%0d", i), 32'(ex[i]));
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (32'(fwd_sel) !== e.val) begin n_fail++; $display("FAIL %s got %0b expected %0b", e.tag, fwd_sel, e.val); end
            $display("forward: case %0d exmem_rd=%0d memwb_rd=%0d fwd_sel=%b", i, exmem_rd, memwb_rd, fwd_sel);
        end
    endtask

    task automatic test_load_use();
        // {used, rs1, rs0, flush, valid, expected stall}
        logic [1:0] us [5] = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b01};
        logic [3:0] r1 [5] = '{4'd0, 4'd0, 4'd0, 4'd5, 4'd0};
        logic       fl [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic       vl [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic       ex [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_idle();
            idex_is_load   = 1'b1;
            idex_reg_write = 1'b1;
            idex_rd        = 4'd5;
            set_id(r1[i], 4'd5, us[i], 4'd1, 1'b1, 3'd0);
            id_valid = vl[i];
            flush    = fl[i];
            push($sformatf("load_use_case%0d", i), 32'(ex[i]));
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (32'(stall) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, stall, e.val); end
            $display("load_use: case %0d used=%b flush=%0d stall=%0d", i, id_rs_used, flush, stall);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_mul_raw();
        // MUL r4 lat=3 issues; the dependent read then sees cnt[4] = 3,2,1,0
        @(negedge clk);
        drive_idle();
        set_id(4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 3'd3);
        push("mul_issue_stall", 32'h0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(stall) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, stall, e.val); end
        for (int i = 0; i < 4; i++) begin
            push($sformatf("raw_stall_c%0d", i), (i < 3) ? 32'h1 : 32'h0);
            push($sformatf("raw_busy4_c%0d", i), (i < 3) ? 32'h1 : 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_id(4'd0, 4'd4, 2'b01, 4'd0, 1'b0, 3'd0);
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (32'(stall) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, stall, e.val); end
            e = exp_q.pop_front(); n_checks++;
            if (32'(busy_map[4]) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, busy_map[4], e.val); end
            $display("raw: cycle %0d stall=%0d busy_map=%h", i, stall, busy_map);
        end
        @(negedge clk);
        drive_idle();
    endtask

    task automatic test_struct();
        @(negedge clk);
        set_id(4'd0, 4'd0, 2'b00, 4'd2, 1'b1, 3'd3);
        for (int i = 0; i < 4; i++) push($sformatf("struct_stall_c%0d", i), (i < 3) ? 32'h1 : 32'h0);
        push("div_busy_map", 32'h0200);
        push("div_mc_busy_c0", 32'h1);
        push("div_mc_busy_c1", 32'h1);
        push("div_mc_busy_c2", 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_id(4'd0, 4'd0, 2'b00, 4'd9, 1'b1, 3'd2);
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (32'(stall) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, stall, e.val); end
            $display("struct: cycle %0d mc_busy=%0d stall=%0d", i, mc_busy, stall);
        end
        @(negedge clk);
        drive_idle();
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(busy_map) !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.tag, busy_map, e.val); end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                #1;
            end
            e = exp_q.pop_front(); n_checks++;
            if (32'(mc_busy) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, mc_busy, e.val); end
            $display("struct: drain %0d mc_busy=%0d", i, mc_busy);
        end
    endtask

    task automatic test_waw();
        // MUL r7 lat=3; a flushed writer of r7 must leave the counter intact
        @(negedge clk);
        set_id(4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 3'd3);
        push("waw_flush_stall", 32'h0);
        push("waw_stall_c1", 32'h1);
        push("waw_stall_c2", 32'h1);
        push("waw_stall_c3", 32'h0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_id(4'd0, 4'd0, 2'b00, 4'd7, 1'b1, 3'd0);
            flush = (i == 0);
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (32'(stall) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, stall, e.val); end
            $display("waw: cycle %0d flush=%0d busy_map=%h stall=%0d", i, flush, busy_map, stall);
        end
        @(negedge clk);
        set_id(4'd0, 4'd0, 2'b00, 4'd8, 1'b1, 3'd3);
        push("waw_rd0_stall", 32'h0);
        push("waw_rd0_busy_map", 32'h0100);
        @(negedge clk);
        set_id(4'd0, 4'd0, 2'b00, 4'd0, 1'b1, 3'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(stall) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, stall, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(busy_map) !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.tag, busy_map, e.val); end
        $display("waw: rd=0 write stall=%0d busy_map=%h", stall, busy_map);
        @(negedge clk);
        drive_idle();
        repeat (4) @(negedge clk);
    endtask

    task automatic test_stats_and_reset();
        @(negedge clk);
        drive_idle();
        clr_stats = 1'b1;
        push("stats_cleared", 32'h0);
        for (int i = 1; i <= 20; i++) push($sformatf("stats_after_%0d", i), (i < 15) ? 32'(i) : 32'd15);
        push("stats_clr_priority", 32'h0);
        @(negedge clk);
        clr_stats      = 1'b0;
        idex_is_load   = 1'b1;
        idex_reg_write = 1'b1;
        idex_rd        = 4'd5;
        set_id(4'd0, 4'd5, 2'b01, 4'd0, 1'b0, 3'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(stall_cycles) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, stall_cycles, e.val); end
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            clr_stats = (i == 20);
            #1;
            e = exp_q.pop_front(); n_checks++;
            if (32'(stall_cycles) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, stall_cycles, e.val); end
            $display("stats: cycle %0d stall=%0d stall_cycles=%0d", i, stall, stall_cycles);
        end
        @(negedge clk);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(stall_cycles) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, stall_cycles, e.val); end
        $display("stats: clr with stall stall_cycles=%0d", stall_cycles);
        drive_idle();
        set_id(4'd0, 4'd0, 2'b00, 4'd4, 1'b1, 3'd5);
        push("mid_mul_busy_map", 32'h0010);
        push("mid_mul_mc_busy", 32'h1);
        push("rst_busy_map", 32'h0);
        push("rst_mc_busy", 32'h0);
        push("rst_stall_from_inputs", 32'h1);
        @(negedge clk);
        drive_idle();
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(busy_map) !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.tag, busy_map, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(mc_busy) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, mc_busy, e.val); end
        rst_n = 1'b0;
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(busy_map) !== e.val) begin n_fail++; $display("FAIL %s got %h expected %h", e.tag, busy_map, e.val); end
        e = exp_q.pop_front(); n_checks++;
        if (32'(mc_busy) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, mc_busy, e.val); end
        idex_is_load   = 1'b1;
        idex_reg_write = 1'b1;
        idex_rd        = 4'd5;
        set_id(4'd0, 4'd5, 2'b01, 4'd0, 1'b0, 3'd0);
        #1;
        e = exp_q.pop_front(); n_checks++;
        if (32'(stall) !== e.val) begin n_fail++; $display("FAIL %s got %0d expected %0d", e.tag, stall, e.val); end
        $display("reset_mid_mul: busy_map=%h mc_busy=%0d stall=%0d", busy_map, mc_busy, stall);
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_mul_raw();
        test_struct();
        test_waw();
        test_stats_and_reset();
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain got %0d leftover expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
